// File: rtl/id_issue_ctrl_pkg.sv
// Shared definitions for the ID issue controller: RV32I major opcodes,
// controller state encoding and the hard-wired zero register index.
package id_issue_ctrl_pkg;

    localparam logic [4:0] X0 = 5'd0;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/id_issue_ctrl_decoder.sv
// Combinational RV32I field decoder. Register pointers an instruction format
// does not use are returned as x0 so they never create false hazards.
module decoder
    import id_issue_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [31:0] imm_o,
    output logic        invalid_o
);

    always_comb begin
        rs1_o     = X0;
        rs2_o     = X0;
        rd_o      = X0;
        imm_o     = '0;
        invalid_o = 1'b0;
        case (instr_i[6:0])
            OPC_LUI, OPC_AUIPC: begin
                rd_o  = instr_i[11:7];
                imm_o = {instr_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                rd_o  = instr_i[11:7];
                imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: begin
                rd_o  = instr_i[11:7];
                rs1_o = instr_i[19:15];
                imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_STORE: begin
                rs1_o = instr_i[19:15];
                rs2_o = instr_i[24:20];
                imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPC_BRANCH: begin
                rs1_o = instr_i[19:15];
                rs2_o = instr_i[24:20];
                imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OPC_OP: begin
                rd_o  = instr_i[11:7];
                rs1_o = instr_i[19:15];
                rs2_o = instr_i[24:20];
            end
            OPC_MISC_MEM: begin
                imm_o = '0;
            end
            default: invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_issue_ctrl_scoreboard.sv
// 32-entry busy vector for in-flight destination registers. A set and a clear
// of the same index in one cycle leaves the entry busy; x0 is never busy.
module id_scoreboard
    import id_issue_ctrl_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_en_i,
    input  logic [4:0] set_idx_i,
    input  logic       clr_en_i,
    input  logic [4:0] clr_idx_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic [4:0] rd_i,
    output logic       rs1_busy_o,
    output logic       rs2_busy_o,
    output logic       rd_busy_o
);

    logic [31:0] busy_q;
    logic [31:0] busy_d;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] view;

    always_comb begin
        set_mask = set_en_i ? (32'd1 << set_idx_i) : '0;
        clr_mask = clr_en_i ? (32'd1 << clr_idx_i) : '0;
        busy_d   = (busy_q & ~clr_mask) | set_mask;
        busy_d[X0] = 1'b0;
        // With bypass, a writeback in this cycle already frees its register.
        view     = WB_BYPASS ? (busy_q & ~clr_mask) : busy_q;
    end

    assign rs1_busy_o = view[rs1_i];
    assign rs2_busy_o = view[rs2_i];
    assign rd_busy_o  = view[rd_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage sequencer: decodes IF instructions into the ID/EX register,
// stalls on RAW/WAW hazards against in-flight writes and halts on illegal opcodes.
module id_issue_ctrl
    import id_issue_ctrl_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        if_valid_i,
    output logic        if_ready_o,
    input  logic [31:0] if_instr_i,
    input  logic [31:0] if_pc_i,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic [31:0] ex_instr_o,
    output logic [31:0] ex_pc_o,
    output logic [4:0]  ex_rs1_o,
    output logic [4:0]  ex_rs2_o,
    output logic [4:0]  ex_rd_o,
    output logic [31:0] ex_imm_o,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_i,
    input  logic        flush_i,
    output logic        illegal_o,
    output logic [31:0] illegal_pc_o,
    output logic        halted_o
);

    state_e      state_q, state_d;
    logic        ex_valid_q, ex_valid_d;
    logic [31:0] ex_instr_q, ex_instr_d;
    logic [31:0] ex_pc_q, ex_pc_d;
    logic [4:0]  ex_rs1_q, ex_rs1_d;
    logic [4:0]  ex_rs2_q, ex_rs2_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic [31:0] ex_imm_q, ex_imm_d;
    logic        illegal_q, illegal_d;
    logic [31:0] illegal_pc_q, illegal_pc_d;

    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [31:0] dec_imm;
    logic        dec_invalid;
    logic        rs1_busy, rs2_busy, rd_busy;
    logic        ex_rd_live;
    logic        hz;
    logic        accept;
    logic        issue;

    decoder u_decoder (
        .instr_i   (if_instr_i),
        .rs1_o     (dec_rs1),
        .rs2_o     (dec_rs2),
        .rd_o      (dec_rd),
        .imm_o     (dec_imm),
        .invalid_o (dec_invalid)
    );

    id_scoreboard #(
        .WB_BYPASS (WB_BYPASS)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rstn_i),
        .set_en_i   (issue && (ex_rd_q != X0)),
        .set_idx_i  (ex_rd_q),
        .clr_en_i   (wb_valid_i),
        .clr_idx_i  (wb_rd_i),
        .rs1_i      (dec_rs1),
        .rs2_i      (dec_rs2),
        .rd_i       (dec_rd),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .rd_busy_o  (rd_busy)
    );

    // The instruction in ID/EX has not set its scoreboard bit yet, so compare directly.
    assign ex_rd_live = ex_valid_q && (ex_rd_q != X0);
    assign hz = rs1_busy || rs2_busy || rd_busy
             || (ex_rd_live && ((dec_rs1 == ex_rd_q) || (dec_rs2 == ex_rd_q)
                                || (dec_rd == ex_rd_q)));

    assign if_ready_o = (state_q == ST_RUN) && !flush_i && !hz
                     && (!ex_valid_q || ex_ready_i);
    assign accept     = if_valid_i && if_ready_o;
    assign issue      = ex_valid_q && ex_ready_i;

    always_comb begin
        state_d      = state_q;
        ex_valid_d   = ex_valid_q;
        ex_instr_d   = ex_instr_q;
        ex_pc_d      = ex_pc_q;
        ex_rs1_d     = ex_rs1_q;
        ex_rs2_d     = ex_rs2_q;
        ex_rd_d      = ex_rd_q;
        ex_imm_d     = ex_imm_q;
        illegal_d    = 1'b0;
        illegal_pc_d = illegal_pc_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
            state_d    = ST_RUN;
        end else if (accept && !dec_invalid) begin
            ex_valid_d = 1'b1;
            ex_instr_d = if_instr_i;
            ex_pc_d    = if_pc_i;
            ex_rs1_d   = dec_rs1;
            ex_rs2_d   = dec_rs2;
            ex_rd_d    = dec_rd;
            ex_imm_d   = dec_imm;
        end else begin
            if (issue) begin
                ex_valid_d = 1'b0;
            end
            if (accept && dec_invalid) begin
                illegal_d    = 1'b1;
                illegal_pc_d = if_pc_i;
                state_d      = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_RUN;
            ex_valid_q   <= 1'b0;
            ex_instr_q   <= '0;
            ex_pc_q      <= '0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_rd_q      <= '0;
            ex_imm_q     <= '0;
            illegal_q    <= 1'b0;
            illegal_pc_q <= '0;
        end else begin
            state_q      <= state_d;
            ex_valid_q   <= ex_valid_d;
            ex_instr_q   <= ex_instr_d;
            ex_pc_q      <= ex_pc_d;
            ex_rs1_q     <= ex_rs1_d;
            ex_rs2_q     <= ex_rs2_d;
            ex_rd_q      <= ex_rd_d;
            ex_imm_q     <= ex_imm_d;
            illegal_q    <= illegal_d;
            illegal_pc_q <= illegal_pc_d;
        end
    end

    assign ex_valid_o   = ex_valid_q;
    assign ex_instr_o   = ex_instr_q;
    assign ex_pc_o      = ex_pc_q;
    assign ex_rs1_o     = ex_rs1_q;
    assign ex_rs2_o     = ex_rs2_q;
    assign ex_rd_o      = ex_rd_q;
    assign ex_imm_o     = ex_imm_q;
    assign illegal_o    = illegal_q;
    assign illegal_pc_o = illegal_pc_q;
    assign halted_o     = (state_q == ST_HALT);

endmodule
